// File: rtl/cvxif_coproc_queue.sv
// cvxif_coproc_queue: CVXIF-style coprocessor for custom-3 instructions.
// Buffers up to Depth speculative instructions until the core commits or
// kills them. Committed entries run a fixed Latency countdown. Results
// retire strictly in issue order, with backpressure on the result port.
module cvxif_coproc_queue #(
  parameter int XLEN    = 64,
  parameter int IdWidth = 3,
  parameter int Depth   = 4,
  parameter int Latency = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  output logic                   issue_accept_o,
  input  logic [31:0]            issue_instr_i,
  input  logic [IdWidth-1:0]     issue_id_i,
  input  logic [XLEN-1:0]        issue_rs1_i,
  input  logic [XLEN-1:0]        issue_rs2_i,
  input  logic                   commit_valid_i,
  input  logic [IdWidth-1:0]     commit_id_i,
  input  logic                   commit_kill_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [IdWidth-1:0]     result_id_o,
  output logic [XLEN-1:0]        result_data_o,
  output logic [4:0]             result_rd_o,
  output logic                   result_we_o,
  output logic                   busy_o,
  output logic [$clog2(Depth):0] occupancy_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int OccW = PtrW + 1;
  localparam int CntW = (Latency > 1) ? $clog2(Latency) : 1;
  localparam logic [CntW-1:0] CntLoad       = CntW'(Latency - 1);
  localparam logic [6:0]      OpcodeCustom3 = 7'b1111011;

  typedef enum logic [2:0] {
    ST_FREE,
    ST_WAIT_COMMIT,
    ST_EXEC,
    ST_DONE,
    ST_KILLED
  } entry_state_e;

  // Control state (reset) and payload storage (no reset).
  entry_state_e        state_q [Depth];
  entry_state_e        state_d [Depth];
  logic [CntW-1:0]     cnt_q   [Depth];
  logic [CntW-1:0]     cnt_d   [Depth];
  logic [IdWidth-1:0]  id_q    [Depth];
  logic [4:0]          rd_q    [Depth];
  logic                we_q    [Depth];
  logic [XLEN-1:0]     data_q  [Depth];

  logic [PtrW-1:0] head_q, tail_q;
  logic [OccW-1:0] occ_q, occ_d;
  logic            ready_q;

  logic [2:0]      funct3;
  logic            enq, deq;
  logic            head_has_result, head_killed;
  logic [XLEN-1:0] new_data;
  logic            new_we;
  logic            unused_instr;

  // Only opcode, rd and funct3 carry meaning for this coprocessor.
  assign unused_instr = ^issue_instr_i[31:15];
  assign funct3       = issue_instr_i[14:12];

  // Decode depends on the instruction word alone: custom-3 with funct3 0..3.
  assign issue_accept_o = (issue_instr_i[6:0] == OpcodeCustom3) && !funct3[2];

  assign enq = issue_valid_i && ready_q && issue_accept_o;

  // Result is computed at issue so that execution is only a countdown.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    new_data = '0;
    new_we   = 1'b1;
    case (funct3)
      3'd0:    new_data = issue_rs1_i + issue_rs2_i;
      3'd1:    new_data = issue_rs1_i - issue_rs2_i;
      3'd2:    new_data = issue_rs1_i ^ issue_rs2_i;
      default: new_we   = 1'b0;
    endcase
  end

  // An EXEC head whose countdown has expired is presented immediately, so a
  // commit at the edge ending cycle T yields a result in cycle T+Latency.
  assign head_has_result = (state_q[head_q] == ST_DONE) ||
                           ((state_q[head_q] == ST_EXEC) && (cnt_q[head_q] == '0));
  assign head_killed     = (state_q[head_q] == ST_KILLED);
  assign deq             = (head_has_result && result_ready_i) || head_killed;

  // Occupancy bookkeeping: a simultaneous enqueue and dequeue cancel out.
  always_comb begin
    occ_d = occ_q;
    if (enq && !deq) begin
      occ_d = occ_q + OccW'(1);
    end else if (!enq && deq) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  // Per-entry state transitions, then retirement at the head, then the new
  // tail entry (which may be committed or killed in its own issue cycle).
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_WAIT_COMMIT: begin
          if (commit_valid_i && (id_q[i] == commit_id_i)) begin
            if (commit_kill_i) begin
              state_d[i] = ST_KILLED;
            end else begin
              state_d[i] = ST_EXEC;
              cnt_d[i]   = CntLoad;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_DONE;
          end else begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
          end
        end
        default: ;
      endcase
    end

    // Head and tail never coincide here: when empty there is no dequeue and
    // when full the registered ready blocks the enqueue.
    if (deq) begin
      state_d[head_q] = ST_FREE;
    end

    if (enq) begin
      state_d[tail_q] = ST_WAIT_COMMIT;
      cnt_d[tail_q]   = CntLoad;
      if (commit_valid_i && (commit_id_i == issue_id_i)) begin
        state_d[tail_q] = commit_kill_i ? ST_KILLED : ST_EXEC;
      end
    end
  end

  // Pointers, occupancy, registered issue-ready and entry control state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      ready_q <= 1'b1;
      for (int i = 0; i < Depth; i++) begin
        state_q[i] <= ST_FREE;
        cnt_q[i]   <= '0;
      end
    end else begin
      if (enq) begin
        tail_q <= tail_q + PtrW'(1);
      end
      if (deq) begin
        head_q <= head_q + PtrW'(1);
      end
      occ_q   <= occ_d;
      ready_q <= (occ_d < OccW'(Depth));
      for (int i = 0; i < Depth; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Payload capture at enqueue.
  always_ff @(posedge clk_i) begin
    // NOTE: payload storage is deliberately not reset; a FREE state marks it
    // meaningless and the outputs are gated while nothing is valid.
    if (enq) begin
      id_q[tail_q]   <= issue_id_i;
      rd_q[tail_q]   <= issue_instr_i[11:7];
      we_q[tail_q]   <= new_we;
      data_q[tail_q] <= new_data;
    end
  end

  assign issue_ready_o  = ready_q;
  assign result_valid_o = head_has_result;
  assign result_id_o    = head_has_result ? id_q[head_q]   : '0;
  assign result_data_o  = head_has_result ? data_q[head_q] : '0;
  assign result_rd_o    = head_has_result ? rd_q[head_q]   : '0;
  assign result_we_o    = head_has_result ? we_q[head_q]   : 1'b0;
  assign occupancy_o    = occ_q;
  assign busy_o         = (occ_q != '0);

endmodule

// File: tb/tb_cvxif_coproc_queue.sv
// Testbench for cvxif_coproc_queue: decode/arithmetic vector table plus
// hand-written sequences for latency, kill, full, ordering and reset.
module tb_cvxif_coproc_queue;

  localparam int XLEN    = 64;
  localparam int IdWidth = 3;
  localparam int Depth   = 4;
  localparam int Latency = 2;
  localparam logic [6:0] Custom3 = 7'b1111011;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   issue_valid;
  logic                   issue_ready;
  logic                   issue_accept;
  logic [31:0]            issue_instr;
  logic [IdWidth-1:0]     issue_id;
  logic [XLEN-1:0]        issue_rs1, issue_rs2;
  logic                   commit_valid;
  logic [IdWidth-1:0]     commit_id;
  logic                   commit_kill;
  logic                   result_valid;
  logic                   result_ready;
  logic [IdWidth-1:0]     result_id;
  logic [XLEN-1:0]        result_data;
  logic [4:0]             result_rd;
  logic                   result_we;
  logic                   busy;
  logic [$clog2(Depth):0] occupancy;

  cvxif_coproc_queue #(
    .XLEN(XLEN), .IdWidth(IdWidth), .Depth(Depth), .Latency(Latency)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_accept_o(issue_accept), .issue_instr_i(issue_instr),
    .issue_id_i(issue_id), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id),
    .commit_kill_i(commit_kill),
    .result_valid_o(result_valid), .result_ready_i(result_ready),
    .result_id_o(result_id), .result_data_o(result_data),
    .result_rd_o(result_rd), .result_we_o(result_we),
    .busy_o(busy), .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IdWidth-1:0] id;
    logic [4:0]         rd;
    logic               we;
    logic [XLEN-1:0]    data;
  } res_t;

  typedef struct {
    logic [2:0]      f3;
    logic [6:0]      opc;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            accept;
    logic            we;
    logic [XLEN-1:0] data;
  } vec_t;

  res_t exp_q[$];
  res_t mon_e;
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   results_seen = 0;
  int   base_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
    return {17'd0, f3, rd, opc};
  endfunction

  // Reference behaviour of one accepted instruction.
  function automatic res_t model(input logic [IdWidth-1:0] id, input logic [31:0] instr,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    res_t r;
    r.id   = id;
    r.rd   = instr[11:7];
    r.we   = 1'b1;
    r.data = '0;
    case (instr[14:12])
      3'd0:    r.data = a + b;
      3'd1:    r.data = a - b;
      3'd2:    r.data = a ^ b;
      default: r.we = 1'b0;
    endcase
    return r;
  endfunction

  // Scoreboard: every handshake seen half a cycle before the edge is compared
  // with the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      results_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id %0d, expected no result", result_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_id", 64'(result_id), 64'(mon_e.id));
        check("sb_data", result_data, mon_e.data);
        check("sb_rd", 64'(result_rd), 64'(mon_e.rd));
        check("sb_we", 64'(result_we), 64'(mon_e.we));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [IdWidth-1:0] id, input logic [31:0] instr,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    issue_valid = 1'b1;
    issue_id    = id;
    issue_instr = instr;
    issue_rs1   = a;
    issue_rs2   = b;
    exp_q.push_back(model(id, instr, a, b));
    step();
    issue_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [IdWidth-1:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    if (kill) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i].id == id) begin
          exp_q.delete(i);
          break;
        end
      end
    end
    step();
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((occupancy != 0 || exp_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    check(name, 64'(occupancy == 0 && exp_q.size() == 0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    issue_valid  = 1'b0;
    issue_instr  = '0;
    issue_id     = '0;
    issue_rs1    = '0;
    issue_rs2    = '0;
    commit_valid = 1'b0;
    commit_id    = '0;
    commit_kill  = 1'b0;
    result_ready = 1'b1;

    vecs[0] = '{3'd0, Custom3, 5'd3, 64'd5, 64'd7, 1'b1, 1'b1, 64'd12};
    vecs[1] = '{3'd1, Custom3, 5'd4, 64'd3, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{3'd2, Custom3, 5'd9, 64'hF0F0, 64'hFF00, 1'b1, 1'b1, 64'h0FF0};
    vecs[3] = '{3'd3, Custom3, 5'd7, 64'd11, 64'd22, 1'b1, 1'b0, 64'd0};
    vecs[4] = '{3'd5, Custom3, 5'd1, 64'd1, 64'd1, 1'b0, 1'b0, 64'd0};
    vecs[5] = '{3'd0, 7'h33, 5'd1, 64'd1, 64'd1, 1'b0, 1'b0, 64'd0};
    vecs[6] = '{3'd0, Custom3, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b1, 64'd1};

    // Reset state.
    #3;
    check("rst_ready", 64'(issue_ready), 64'd1);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_payload", {result_data ^ 64'(result_id)} | 64'(result_rd) | 64'(result_we), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Decode and arithmetic vectors, each issued, committed and drained.
    for (int i = 0; i < 7; i++) begin
      issue_instr = mk_instr(vecs[i].f3, vecs[i].rd, vecs[i].opc);
      issue_rs1   = vecs[i].rs1;
      issue_rs2   = vecs[i].rs2;
      issue_id    = IdWidth'(i);
      #1;
      check($sformatf("vec%0d_accept", i), 64'(issue_accept), 64'(vecs[i].accept));
      if (vecs[i].accept) begin
        exp_q.push_back('{IdWidth'(i), vecs[i].rd, vecs[i].we, vecs[i].data});
      end
      issue_valid = 1'b1;
      step();
      issue_valid = 1'b0;
      check($sformatf("vec%0d_occ", i), 64'(occupancy), vecs[i].accept ? 64'd1 : 64'd0);
      if (vecs[i].accept) begin
        do_commit(IdWidth'(i), 1'b0);
      end
      wait_drain($sformatf("vec%0d_drain", i));
    end

    // ADD latency: commit at cycle T, result exactly in cycle T+2.
    do_issue(3'd1, mk_instr(3'd0, 5'd3, Custom3), 64'd5, 64'd7);
    do_commit(3'd1, 1'b0);
    check("lat_t1_valid", 64'(result_valid), 64'd0);
    step();
    check("lat_t2_valid", 64'(result_valid), 64'd1);
    check("lat_t2_id", 64'(result_id), 64'd1);
    check("lat_t2_data", result_data, 64'd12);
    check("lat_t2_rd", 64'(result_rd), 64'd3);
    check("lat_t2_we", 64'(result_we), 64'd1);
    step();
    check("lat_after_valid", 64'(result_valid), 64'd0);
    wait_drain("lat_drain");

    // Commit in the same cycle as the issue of that ID.
    commit_valid = 1'b1;
    commit_id    = 3'd3;
    do_issue(3'd3, mk_instr(3'd0, 5'd8, Custom3), 64'd1, 64'd1);
    commit_valid = 1'b0;
    check("same_t1_valid", 64'(result_valid), 64'd0);
    step();
    check("same_t2_valid", 64'(result_valid), 64'd1);
    wait_drain("same_drain");

    // Kill the older entry, commit the younger one.
    base_seen = results_seen;
    do_issue(3'd0, mk_instr(3'd0, 5'd10, Custom3), 64'd100, 64'd1);
    do_issue(3'd1, mk_instr(3'd1, 5'd11, Custom3), 64'd100, 64'd1);
    check("kill_occ_before", 64'(occupancy), 64'd2);
    do_commit(3'd0, 1'b1);
    check("kill_occ_killed", 64'(occupancy), 64'd2);
    do_commit(3'd1, 1'b0);
    check("kill_occ_reclaimed", 64'(occupancy), 64'd1);
    wait_drain("kill_drain");
    check("kill_result_count", 64'(results_seen - base_seen), 64'd1);

    // Full queue: fifth issue held until a pop frees a slot.
    for (int i = 0; i < 4; i++) begin
      do_issue(IdWidth'(i), mk_instr(3'd0, 5'(i + 1), Custom3), 64'(i), 64'd100);
    end
    check("full_occ", 64'(occupancy), 64'd4);
    check("full_ready", 64'(issue_ready), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    issue_valid = 1'b1;
    issue_id    = 3'd4;
    issue_instr = mk_instr(3'd2, 5'd20, Custom3);
    issue_rs1   = 64'h55;
    issue_rs2   = 64'hFF;
    step();
    check("full_held_occ", 64'(occupancy), 64'd4);
    do_commit(3'd0, 1'b0);
    check("full_t1_ready", 64'(issue_ready), 64'd0);
    step();
    check("full_t2_valid", 64'(result_valid), 64'd1);
    check("full_t2_ready", 64'(issue_ready), 64'd0);
    step();
    check("full_t3_ready", 64'(issue_ready), 64'd1);
    check("full_t3_occ", 64'(occupancy), 64'd3);
    exp_q.push_back(model(3'd4, issue_instr, issue_rs1, issue_rs2));
    step();
    issue_valid = 1'b0;
    check("full_refill_occ", 64'(occupancy), 64'd4);
    for (int i = 1; i < 5; i++) begin
      do_commit(IdWidth'(i), 1'b0);
    end
    wait_drain("full_drain");

    // Ordering and backpressure: younger ID 1 commits first but waits.
    result_ready = 1'b0;
    do_issue(3'd2, mk_instr(3'd0, 5'd5, Custom3), 64'd10, 64'd20);
    do_issue(3'd1, mk_instr(3'd2, 5'd6, Custom3), 64'hAA, 64'h0F);
    do_commit(3'd1, 1'b0);
    do_commit(3'd2, 1'b0);
    begin
      int n = 0;
      while (!result_valid && n < 20) begin
        step();
        n++;
      end
    end
    check("order_valid", 64'(result_valid), 64'd1);
    check("order_first_id", 64'(result_id), 64'd2);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("order_hold%0d", k),
            {result_data[59:0], 1'(result_valid), 3'(result_id)}, {60'd30, 1'b1, 3'd2});
    end
    result_ready = 1'b1;
    wait_drain("order_drain");

    // Reset mid-queue with three waiting entries.
    base_seen = results_seen;
    do_issue(3'd5, mk_instr(3'd0, 5'd1, Custom3), 64'd1, 64'd2);
    do_issue(3'd6, mk_instr(3'd1, 5'd2, Custom3), 64'd3, 64'd4);
    do_issue(3'd7, mk_instr(3'd2, 5'd3, Custom3), 64'd5, 64'd6);
    check("mid_occ", 64'(occupancy), 64'd3);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_valid", 64'(result_valid), 64'd0);
    check("mid_rst_ready", 64'(issue_ready), 64'd1);
    step();
    rst = 1'b0;
    do_commit(3'd5, 1'b0);
    for (int k = 0; k < 6; k++) step();
    check("mid_after_occ", 64'(occupancy), 64'd0);
    check("mid_no_results", 64'(results_seen - base_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
